// File: rtl/irq_sequencer.sv
// irq_sequencer: prioritised edge-triggered interrupt sequencer.
// Redirects the PC to a source vector on dispatch and back on RETI.
module irq_sequencer #(
  parameter int          NSRC            = 4,
  parameter logic [15:0] VEC_BASE        = 16'h0040,
  parameter int          VEC_STRIDE_LOG2 = 2,
  parameter logic [5:0]  RETI_OP         = 6'b011111
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] irq_in,
  input  logic [NSRC-1:0] irq_mask,
  input  logic [5:0]      op,
  input  logic [15:0]     current_address,
  input  logic [1:0]      flag_ex,
  output logic            pc_mux_sel,
  output logic [15:0]     jmp_loc,
  output logic [1:0]      flag_restore,
  output logic            flag_restore_en,
  output logic [NSRC-1:0] irq_ack,
  output logic            in_isr,
  output logic [1:0]      active_id
);

  typedef enum logic [1:0] {
    IDLE,
    VECTOR,
    ISR,
    RETURN
  } state_t;

  state_t state, state_nx;

  logic [NSRC-1:0] irq_prev;
  logic [NSRC-1:0] pending;
  logic [NSRC-1:0] edges;
  logic [NSRC-1:0] eligible;
  logic [NSRC-1:0] ack;
  logic [1:0]      sel_id;
  logic [1:0]      id_q;
  logic [15:0]     saved_pc;
  logic [1:0]      saved_flags;
  logic [15:0]     vec_addr;
  logic            dispatch;

  assign edges    = irq_in & ~irq_prev;
  assign eligible = pending & irq_mask;
  assign dispatch = (state == IDLE) && (eligible != '0);
  assign vec_addr = VEC_BASE + (16'(id_q) << VEC_STRIDE_LOG2);

  // lowest eligible index wins
  always_comb begin
    sel_id = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (eligible[i]) sel_id = 2'(i);
    end
  end

  // one-hot acknowledge while vectoring
  always_comb begin
    ack = '0;
    for (int i = 0; i < NSRC; i++) begin
      ack[i] = (state == VECTOR) && (id_q == 2'(i));
    end
  end

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // edge history, pending set/clear (set wins) and dispatch capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_prev    <= '0;
      pending     <= '0;
      id_q        <= '0;
      saved_pc    <= '0;
      saved_flags <= '0;
    end else begin
      irq_prev <= irq_in;
      pending  <= (pending & ~ack) | edges;
      if (dispatch) begin
        id_q        <= sel_id;
        saved_pc    <= current_address;
        saved_flags <= flag_ex;
      end
    end
  end

  // next-state logic; no nesting while in an ISR
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (dispatch) state_nx = VECTOR;
      VECTOR:  state_nx = ISR;
      ISR:     if (op == RETI_OP) state_nx = RETURN;
      RETURN:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Moore outputs decoded from state and saved registers
  always_comb begin
    pc_mux_sel      = 1'b0;
    jmp_loc         = 16'h0000;
    flag_restore_en = 1'b0;
    in_isr          = 1'b1;
    unique case (state)
      IDLE:    in_isr = 1'b0;
      VECTOR: begin
        pc_mux_sel = 1'b1;
        jmp_loc    = vec_addr;
      end
      ISR:     ;
      RETURN: begin
        pc_mux_sel      = 1'b1;
        jmp_loc         = saved_pc;
        flag_restore_en = 1'b1;
      end
      default: in_isr = 1'b0;
    endcase
  end

  assign irq_ack      = ack;
  assign flag_restore = saved_flags;
  assign active_id    = id_q;

endmodule

// File: tb/tb_irq_sequencer.sv
// tb_irq_sequencer: scoreboard bench for irq_sequencer.
// Timestamp-based reference model predicts redirect events.
module tb_irq_sequencer;

  localparam logic [5:0] RETI = 6'b011111;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  irq_in = 4'h0;
  logic [3:0]  irq_mask = 4'hF;
  logic [5:0]  op = 6'd0;
  logic [15:0] current_address = 16'h0000;
  logic [1:0]  flag_ex = 2'b00;

  logic        pc_mux_sel;
  logic [15:0] jmp_loc;
  logic [1:0]  flag_restore;
  logic        flag_restore_en;
  logic [3:0]  irq_ack;
  logic        in_isr;
  logic [1:0]  active_id;

  irq_sequencer dut (
    .clk(clk),
    .reset(reset),
    .irq_in(irq_in),
    .irq_mask(irq_mask),
    .op(op),
    .current_address(current_address),
    .flag_ex(flag_ex),
    .pc_mux_sel(pc_mux_sel),
    .jmp_loc(jmp_loc),
    .flag_restore(flag_restore),
    .flag_restore_en(flag_restore_en),
    .irq_ack(irq_ack),
    .in_isr(in_isr),
    .active_id(active_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [15:0] loc;
    logic [3:0]  ack;
    logic        fen;
    logic [1:0]  fr;
    logic [1:0]  id;
  } ev_t;

  ev_t  q[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc = 0;
  bit   hold = 1'b0;

  logic [3:0]  m_pend = 4'h0;
  logic [3:0]  m_prev = 4'h0;
  bit          m_busy = 1'b0;
  int          m_disp = -10;
  int          m_free = 0;
  int          m_clr_at = -1;
  logic [15:0] m_pc = 16'h0;
  logic [1:0]  m_flags = 2'b0;
  logic [1:0]  m_id = 2'b0;
  bit          exp_isr = 1'b0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // reference model: one redirect event per dispatch and per return
  always @(posedge clk) begin
    logic [3:0] rise;
    logic [3:0] elig;
    bit         ret_now;
    ev_t        e;
    ret_now = 1'b0;
    if (!reset) begin
      m_pend   = 4'h0;
      m_prev   = 4'h0;
      m_busy   = 1'b0;
      m_free   = 0;
      m_clr_at = -1;
      exp_isr  = 1'b0;
      q.delete();
    end else begin
      rise = irq_in & ~m_prev;
      elig = m_pend & irq_mask;
      if (m_busy) begin
        if (cyc > m_disp + 1 && op == RETI) begin
          e.cyc = cyc; e.loc = m_pc; e.ack = 4'h0;
          e.fen = 1'b1; e.fr = m_flags; e.id = m_id;
          q.push_back(e);
          m_busy  = 1'b0;
          m_free  = cyc + 2;
          ret_now = 1'b1;
        end
      end else if (cyc >= m_free && elig != 4'h0) begin
        for (int i = 3; i >= 0; i--) if (elig[i]) m_id = 2'(i);
        m_pc    = current_address;
        m_flags = flag_ex;
        e.cyc = cyc;
        e.loc = 16'h0040 + 16'(int'(m_id) * 4);
        e.ack = 4'(1 << m_id);
        e.fen = 1'b0; e.fr = m_flags; e.id = m_id;
        q.push_back(e);
        m_busy   = 1'b1;
        m_disp   = cyc;
        m_clr_at = cyc + 1;
      end
      if (cyc == m_clr_at) m_pend[m_id] = 1'b0;
      m_pend  = m_pend | rise;
      m_prev  = irq_in;
      exp_isr = m_busy || ret_now;
    end
    cyc++;
  end

  // monitor: pops an expected event whenever one is due
  always @(posedge clk) begin
    ev_t e;
    #1;
    if (!reset) begin
      check("reset_outputs",
            32'({pc_mux_sel, jmp_loc, flag_restore, flag_restore_en,
                 irq_ack, in_isr, active_id}), 32'd0);
    end else begin
      check("in_isr", 32'(in_isr), 32'(exp_isr));
      if (q.size() != 0) begin
        e = q.pop_front();
        check("pc_mux_sel", 32'(pc_mux_sel), 32'd1);
        check("jmp_loc", 32'(jmp_loc), 32'(e.loc));
        check("irq_ack", 32'(irq_ack), 32'(e.ack));
        check("flag_restore_en", 32'(flag_restore_en), 32'(e.fen));
        check("flag_restore", 32'(flag_restore), 32'(e.fr));
        check("active_id", 32'(active_id), 32'(e.id));
      end else begin
        check("quiet", 32'({pc_mux_sel, flag_restore_en, irq_ack}), 32'd0);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      if (!hold) begin
        current_address = 16'($urandom);
        flag_ex         = 2'($urandom);
      end
    end
  endtask

  task automatic wait_busy();
    for (int i = 0; i < 40 && !m_busy; i++) tick();
  endtask

  task automatic serve(input int n);
    bit ok;
    repeat (n) begin
      wait_busy();
      ok = m_busy;
      check("dispatch_timeout", 32'(ok), 32'd1);
      if (ok) begin
        tick(2);
        op = RETI;
        tick();
        op = 6'd0;
        tick();
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // lines already high at reset release
    reset  = 1'b0;
    irq_in = 4'hF;
    #8 reset = 1'b1;
    serve(4);
    irq_in = 4'h0;
    tick(3);

    // simultaneous sources 2 and 1
    hold = 1'b1;
    current_address = 16'h0001;
    irq_in = 4'b0110;
    tick();
    irq_in = 4'h0;
    serve(2);
    hold = 1'b0;
    tick(3);

    // masked source waits for unmask
    irq_mask = 4'b0111;
    irq_in = 4'b1000;
    tick();
    irq_in = 4'h0;
    tick(10);
    irq_mask = 4'hF;
    serve(1);
    tick(3);

    // flags captured at dispatch survive ISR changes
    hold = 1'b1;
    flag_ex = 2'b11;
    irq_in = 4'b0100;
    tick();
    irq_in = 4'h0;
    wait_busy();
    flag_ex = 2'b00;
    serve(1);
    hold = 1'b0;
    tick(3);

    // RETI while idle is ignored
    op = RETI;
    tick(3);
    op = 6'd0;
    tick(2);

    // new edge on source 0 during its own VECTOR cycle
    irq_in = 4'b0001;
    tick();
    irq_in = 4'h0;
    tick();
    irq_in = 4'b0001;
    tick();
    irq_in = 4'h0;
    serve(2);
    tick(3);

    // reset in ISR with source 1 pending
    irq_in = 4'b0100;
    tick();
    irq_in = 4'h0;
    wait_busy();
    tick();
    irq_in = 4'b0010;
    tick();
    irq_in = 4'h0;
    tick();
    reset = 1'b0;
    #1;
    check("abort_in_isr", 32'(in_isr), 32'd0);
    check("abort_pc_mux", 32'(pc_mux_sel), 32'd0);
    tick(2);
    reset = 1'b1;
    tick(10);

    // randomized traffic
    for (int c = 0; c < 300; c++) begin
      irq_in = irq_in ^ (4'($urandom) & 4'($urandom) & 4'($urandom));
      if ($urandom_range(0, 9) == 0) irq_mask = 4'($urandom);
      op = ($urandom_range(0, 5) == 0) ? RETI : 6'($urandom_range(0, 30));
      tick();
    end
    irq_in = 4'h0;
    op = 6'd0;
    irq_mask = 4'hF;
    tick(2);
    for (int i = 0; i < 12 && (m_busy || m_pend != 4'h0); i++) serve(1);
    tick(5);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/irq_sequencer.md
# irq_sequencer

Prioritised interrupt sequencer for the 16-bit MIPS core. It latches edge-triggered requests from up to NSRC sources, selects one, and redirects the PC to that source's vector while saving the return address and execute-stage flags. When the ISR executes the return-from-interrupt opcode, it redirects the PC back and restores the flags. It sits beside Jump_Control, and its pc_mux_sel/jmp_loc pair has priority over Jump_Control's at the PC mux.

## Interface
- NSRC, 4, number of interrupt sources (1..4)
- VEC_BASE, 16'h0040, address of the source-0 vector
- VEC_STRIDE_LOG2, 2, vector spacing as log2 of words; vector(i) = VEC_BASE + (i << VEC_STRIDE_LOG2)
- RETI_OP, 6'b011111, opcode that ends an ISR

- clk  in  1  core clock; all state changes on rising edge
- reset  in  1  asynchronous, active-low; 0 clears all state immediately
- irq_in  in  NSRC  raw request lines, synchronous to clk; rising edge = request
- irq_mask  in  NSRC  1 = source enabled for dispatch
- op  in  6  opcode currently in execute
- current_address  in  16  address to resume at; captured on dispatch
- flag_ex  in  2  execute-stage flags; captured on dispatch
- pc_mux_sel  out  1  1 = PC takes jmp_loc this cycle
- jmp_loc  out  16  redirect target (vector or saved return address)
- flag_restore  out  2  saved flags
- flag_restore_en  out  1  1 = flag register loads flag_restore this cycle
- irq_ack  out  NSRC  one-hot pulse for the source being dispatched
- in_isr  out  1  1 from dispatch until return completes
- active_id  out  2  index of the source being serviced

## Operation
- Edge detect: irq_prev register (reset 0). Edge(i) = irq_in[i] & ~irq_prev[i].
- pending[i] is set on edge(i) and cleared when irq_ack[i] is issued. If the set and the clear happen in the same cycle, the set wins, and the source stays pending.
- A masked source stays pending and is dispatched once unmasked. Masking never clears pending.
- Eligible sources are pending & irq_mask. The lowest index has the highest priority.
- FSM states are IDLE, VECTOR, ISR and RETURN. The state register and the saved registers update on clock edges. Outputs are decoded from the state and saved registers (Moore).
  - IDLE: if eligible != 0, latch active_id = highest-priority eligible source, saved_pc = current_address and saved_flags = flag_ex, then go to VECTOR. Otherwise stay in IDLE.
  - VECTOR (1 cycle): pc_mux_sel = 1, jmp_loc = vector(active_id), irq_ack[active_id] = 1. Next state is ISR.
  - ISR: wait. If op == RETI_OP, go to RETURN. New requests keep accumulating in pending, but there is no nesting.
  - RETURN (1 cycle): pc_mux_sel = 1, jmp_loc = saved_pc, flag_restore_en = 1. Next state is IDLE.
- RETI_OP seen in IDLE, VECTOR or RETURN is ignored.
- in_isr = 1 in VECTOR, ISR and RETURN.
- When not redirecting, jmp_loc = 16'h0000. flag_restore always shows saved_flags.
- Vector arithmetic is 16-bit and wraps modulo 2^16.

## Timing
- Reset values are 0 for pc_mux_sel, jmp_loc, flag_restore, flag_restore_en, irq_ack, in_isr and active_id. After reset the state is IDLE and pending, irq_prev, saved_pc and saved_flags are all 0.
- Latency: irq_in rises before edge k. Pending is set at edge k. Dispatch happens at edge k+1, and pc_mux_sel is high from k+1 to k+2. Minimum request-to-redirect time is 2 cycles.
- RETI_OP is sampled at edge m while in ISR. The return redirect is high from m to m+1, and the FSM is back in IDLE at m+1.
- With a source pending at return, the next dispatch is at edge m+2 at the earliest (one IDLE cycle).
- Reset asserted mid-operation (any state) aborts the ISR. All pending requests are lost and no return redirect occurs.
- irq_prev = 0 after reset, so a line already high when reset releases counts as an edge at the first clock.
- A source held high produces exactly one request. It must go low and high again to request again.

## Test plan
- Reset: hold reset = 0 with irq_in = 4'b1111, then release at 8 ns. Required: all outputs 0 during reset; source 0 dispatches 2 clocks after release with jmp_loc = 16'h0040 and irq_ack = 4'b0001.
- Priority: pulse sources 2 and 1 in the same cycle with mask 4'b1111 and current_address = 16'h0001. Required: dispatch to 16'h0044; on RETI_OP, jmp_loc = 16'h0001; one IDLE cycle later, dispatch to 16'h0048.
- Masking: pulse source 3 with mask 4'b0111. Required: no redirect for 10 cycles. After setting mask to 4'b1111: dispatch to 16'h004C.
- Flag save/restore: flag_ex = 2'b11 at dispatch, then flag_ex = 2'b00 during the ISR. Required: on RETI_OP, flag_restore_en = 1 for 1 cycle and flag_restore = 2'b11.
- Spurious RETI: op = 6'b011111 while IDLE. Required: pc_mux_sel stays 0. Also pulse source 0 during its own VECTOR cycle. Required: source 0 is still pending after the ack and re-dispatches after return.
- Reset mid-ISR: assert reset in ISR with source 1 pending. Required: in_isr = 0 immediately, no return redirect, and source 1 is not dispatched after release.
